i2c_pad_bridge: RTL and testbench
=================================

// Module: i2c_pad_bridge
// PURPOSE
//  Parametrised N-channel bridge between CF_I2C_WB-style masters and the user GPIO pads.
//  Per line: 2-flop synchroniser, counter-based glitch filter and open-drain pad drive.
//  Per channel: START/STOP detection, bus-busy FSM and optional SCL stuck-low timeout IRQ.
//  Sits in user_project between the masters' scl/sda ports and io_in/io_out/io_oeb.
// PARAMETERS
//  N_CH        2    number of I2C channels (1..8)
//  FILT_LEN    3    glitch-filter length in clocks; 0 = synchroniser only, no filter
//  OPEN_DRAIN  1    1: pad_out=0 and drive low via oeb only; 0: push-pull (pad_out=o, oeb=~oen)
//  TIMEOUT_CYC 4096 SCL-low clocks before timeout (used only with I2C_PAD_TIMEOUT_EN)
// PORTS
//  wb_clk_i     in   1       clock
//  wb_rst_i     in   1       reset, asynchronous, active-high
//  m_scl_o      in   N_CH    master SCL output value
//  m_scl_oen    in   N_CH    master SCL output enable (1 = drive)
//  m_sda_o      in   N_CH    master SDA output value
//  m_sda_oen    in   N_CH    master SDA output enable (1 = drive)
//  m_scl_i      out  N_CH    filtered SCL to master
//  m_sda_i      out  N_CH    filtered SDA to master
//  pad_in       in   2*N_CH  pad inputs; [2k]=SCL ch k, [2k+1]=SDA ch k
//  pad_out      out  2*N_CH  pad output values, same mapping
//  pad_oeb      out  2*N_CH  pad output enable, active-low, same mapping
//  start_det    out  N_CH    1-clock pulse on START
//  stop_det     out  N_CH    1-clock pulse on STOP
//  bus_busy     out  N_CH    1 between START and STOP
//  timeout_irq  out  N_CH    sticky SCL stuck-low flag
//  irq_clr      in   N_CH    clears timeout_irq of that channel
// BEHAVIOUR
//  Reset: sync flops, filtered lines, m_scl_i and m_sda_i = 1 (idle bus); counters = 0;
//   start_det, stop_det, bus_busy and timeout_irq = 0.
//  Pad drive, combinational:
//   OPEN_DRAIN=1: pad_out=0; pad_oeb = ~(oen & ~o), so the pad is driven only to pull the line low.
//   OPEN_DRAIN=0: pad_out=o; pad_oeb=~oen.
//  Filter, per line: s1<=pad, s2<=s1.
//   If s2==filt: cnt<=0.
//   Elif cnt==FILT_LEN-1: filt<=s2, cnt<=0.
//   Else: cnt++.
//   cnt width $clog2(FILT_LEN+1).
//  Filter latency: a stable pad change appears on filt after 2+FILT_LEN edges.
//   Pulses shorter than FILT_LEN clocks are rejected.
//   FILT_LEN=0: filt=s2 combinationally, latency 2.
//  Detection uses filtered signals and their 1-clock-delayed copies (scl_d, sda_d):
//   START = scl & scl_d & sda_d & ~sda.
//   STOP  = scl & scl_d & ~sda_d & sda.
//   An SDA edge in the same clock as an SCL edge is neither START nor STOP.
//  Bus FSM per channel:
//   IDLE -START-> BUSY; BUSY -STOP-> IDLE; BUSY -START-> BUSY (repeated START, pulse still issued).
//   A STOP seen in IDLE pulses stop_det and stays IDLE.
//   bus_busy = (state==BUSY).
//  Channels fully independent; no shared state between channels.
//  Reset mid-transfer: all channels return to IDLE at once, without waiting for a clock edge.
// CONFIGURATION
//  Macro I2C_PAD_TIMEOUT_EN.
//  Defined: per-channel counter of $clog2(TIMEOUT_CYC+1) bits.
//   Counter clears while filtered SCL=1 and increments while SCL=0, saturating at TIMEOUT_CYC.
//   On reaching TIMEOUT_CYC, timeout_irq<=1 (sticky).
//   irq_clr clears timeout_irq; if set and clear land in the same clock, set wins.
//   The counter keeps its saturated value until SCL returns high.
//  Undefined: no counters; timeout_irq tied 0; irq_clr ignored.
// STRUCTURE
//  i2c_pad_pkg: bus FSM enum (BUS_IDLE, BUS_BUSY), pad-index helper functions scl_idx(k)=2k and sda_idx(k)=2k+1.
//  Sub-module i2c_line_filter (synchroniser + glitch filter, parameter FILT_LEN), 2*N_CH instances.
//  Top holds the pad mux, detectors, FSMs and the timeout logic in a generate loop over N_CH.
// TESTING
//  1. Reset with all pads high -> m_scl_i=m_sda_i=all 1, bus_busy=0.
//     Drive m_sda_oen[0]=1, m_sda_o[0]=0 -> pad_oeb[1]=0, pad_out[1]=0.
//  2. FILT_LEN=3: 2-clock low glitch on pad_in[0] -> m_scl_i[0] stays 1.
//     4-clock low pulse -> m_scl_i[0] goes 0 exactly 5 edges after the pad falls.
//  3. Ch1: SCL high, SDA 1->0 -> one start_det[1] pulse, bus_busy[1]=1.
//     Then repeated START -> second pulse, busy stays 1.
//     Then SDA 0->1 with SCL high -> stop_det[1] pulse, busy=0.
//  4. START on ch0 and STOP on ch1 in the same clock -> both pulses, independent busy states.
//     SDA and SCL toggled in the same clock -> no pulse.
//  5. I2C_PAD_TIMEOUT_EN, TIMEOUT_CYC=16: SCL low for 15 clocks -> no IRQ; for 16 clocks -> timeout_irq=1.
//     irq_clr asserted while SCL still low -> IRQ re-set the same cycle.
//     After SCL goes high, irq_clr -> IRQ cleared.
//  6. Assert wb_rst_i asynchronously in BUSY mid-byte -> bus_busy=0 and filters at 1 before the next clock edge.

Source files
------------

// File: rtl/i2c_pad_pkg.sv
// i2c_pad_pkg: shared types and helpers for the I2C pad bridge.
// Holds the bus-state enum and the pad-index mapping helpers.
// Pad mapping: pad [2k] carries SCL of channel k, pad [2k+1] carries SDA.
package i2c_pad_pkg;

   typedef enum logic [0:0] {
      BUS_IDLE = 1'b0,
      BUS_BUSY = 1'b1
   } bus_state_t;

   function automatic int scl_idx(input int k);
      return k + k;
   endfunction

   function automatic int sda_idx(input int k);
      return k + k + 32'sd1;
   endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: two-flop synchroniser followed by a counter glitch filter.
// Pulses shorter than FILT_LEN clocks are rejected.
// A stable input change reaches filt after 2+FILT_LEN clock edges.
// FILT_LEN=0 leaves only the synchroniser.
// Everything resets to 1, which is the idle bus level.
module i2c_line_filter #(
   parameter int FILT_LEN = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic pad,
   output logic filt
);

   logic s1_r;
   logic s2_r;

   // Bring the asynchronous pad level into the clock domain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_r <= 1'b1;
         s2_r <= 1'b1;
      end else begin
         s1_r <= pad;
         s2_r <= s1_r;
      end
   end

   generate
      if (FILT_LEN == 0) begin : g_nofilt
         assign filt = s2_r;
      end else begin : g_filt
         localparam int CW = $clog2(FILT_LEN + 32'sd1);
         localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 32'sd1);
         localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

         logic [CW-1:0] cnt_r;
         logic          filt_r;

         // Accept a new level only after it has persisted FILT_LEN clocks
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt_r  <= '0;
               filt_r <= 1'b1;
            end else if (s2_r == filt_r) begin
               cnt_r  <= '0;
            end else if (cnt_r == CNT_LAST) begin
               filt_r <= s2_r;
               cnt_r  <= '0;
            end else begin
               cnt_r  <= cnt_r + CNT_ONE;
            end
         end

         assign filt = filt_r;
      end
   endgenerate

endmodule

// File: rtl/i2c_pad_bridge.sv
// i2c_pad_bridge: N-channel bridge between I2C masters and GPIO pads.
// Per line: synchroniser, glitch filter and open-drain or push-pull pad drive.
// Per channel: START/STOP detection and a bus-busy FSM.
// Optional build macro I2C_PAD_TIMEOUT_EN adds a per-channel SCL stuck-low
// timeout with a sticky IRQ. When the macro is undefined, timeout_irq is
// tied to 0 and irq_clr is ignored.
module i2c_pad_bridge
   import i2c_pad_pkg::*;
#(
   parameter int N_CH        = 2,
   parameter int FILT_LEN    = 3,
   parameter int OPEN_DRAIN  = 1,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic [N_CH-1:0]   m_scl_o,
   input  logic [N_CH-1:0]   m_scl_oen,
   input  logic [N_CH-1:0]   m_sda_o,
   input  logic [N_CH-1:0]   m_sda_oen,
   output logic [N_CH-1:0]   m_scl_i,
   output logic [N_CH-1:0]   m_sda_i,
   input  logic [2*N_CH-1:0] pad_in,
   output logic [2*N_CH-1:0] pad_out,
   output logic [2*N_CH-1:0] pad_oeb,
   output logic [N_CH-1:0]   start_det,
   output logic [N_CH-1:0]   stop_det,
   output logic [N_CH-1:0]   bus_busy,
   output logic [N_CH-1:0]   timeout_irq,
   input  logic [N_CH-1:0]   irq_clr
);

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      localparam int SCL_I = scl_idx(k);
      localparam int SDA_I = sda_idx(k);

      logic       scl_s;
      logic       sda_s;
      logic       scl_d_r;
      logic       sda_d_r;
      logic       start_s;
      logic       stop_s;
      logic       start_r;
      logic       stop_r;
      bus_state_t state_r;
      bus_state_t state_nxt_s;

      i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
         .clk  (wb_clk_i),
         .rst  (wb_rst_i),
         .pad  (pad_in[SCL_I]),
         .filt (scl_s)
      );

      i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
         .clk  (wb_clk_i),
         .rst  (wb_rst_i),
         .pad  (pad_in[SDA_I]),
         .filt (sda_s)
      );

      assign m_scl_i[k] = scl_s;
      assign m_sda_i[k] = sda_s;

      // Pad drive: open drain only ever pulls low; push-pull follows the master
      if (OPEN_DRAIN != 0) begin : g_od
         assign pad_out[SCL_I] = 1'b0;
         assign pad_out[SDA_I] = 1'b0;
         assign pad_oeb[SCL_I] = ~(m_scl_oen[k] & ~m_scl_o[k]);
         assign pad_oeb[SDA_I] = ~(m_sda_oen[k] & ~m_sda_o[k]);
      end else begin : g_pp
         assign pad_out[SCL_I] = m_scl_o[k];
         assign pad_out[SDA_I] = m_sda_o[k];
         assign pad_oeb[SCL_I] = ~m_scl_oen[k];
         assign pad_oeb[SDA_I] = ~m_sda_oen[k];
      end

      // SDA may only change while SCL is high both now and one clock ago.
      // This keeps simultaneous SCL/SDA edges from being decoded as events.
      assign start_s = scl_s & scl_d_r &  sda_d_r & ~sda_s;
      assign stop_s  = scl_s & scl_d_r & ~sda_d_r &  sda_s;

      // Bus FSM next state; a repeated START keeps the bus busy
      always_comb begin
         state_nxt_s = state_r;
         case (state_r)
            BUS_IDLE: begin
               if (start_s) state_nxt_s = BUS_BUSY;
               else         state_nxt_s = BUS_IDLE;
            end
            BUS_BUSY: begin
               if (stop_s)  state_nxt_s = BUS_IDLE;
               else         state_nxt_s = BUS_BUSY;
            end
            default: state_nxt_s = BUS_IDLE;
         endcase
      end

      // Delayed line copies, registered event pulses and FSM state
      always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
         if (wb_rst_i) begin
            scl_d_r <= 1'b1;
            sda_d_r <= 1'b1;
            start_r <= 1'b0;
            stop_r  <= 1'b0;
            state_r <= BUS_IDLE;
         end else begin
            scl_d_r <= scl_s;
            sda_d_r <= sda_s;
            start_r <= start_s;
            stop_r  <= stop_s;
            state_r <= state_nxt_s;
         end
      end

      assign start_det[k] = start_r;
      assign stop_det[k]  = stop_r;
      assign bus_busy[k]  = (state_r == BUS_BUSY);

`ifdef I2C_PAD_TIMEOUT_EN
      localparam int TW = $clog2(TIMEOUT_CYC + 32'sd1);
      localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYC);
      localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 32'sd1);
      localparam logic [TW-1:0] TO_ONE  = TW'(32'd1);

      logic [TW-1:0] to_cnt_r;
      logic          irq_r;
      logic          to_set_s;

      // Raised on the clock the count reaches TIMEOUT_CYC.
      // It stays asserted while saturated so that it overrides a clear.
      assign to_set_s = ~scl_s & (to_cnt_r >= TO_LAST);

      // Count SCL-low clocks, saturating until SCL is released
      always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
         if (wb_rst_i) begin
            to_cnt_r <= '0;
         end else if (scl_s) begin
            to_cnt_r <= '0;
         end else if (to_cnt_r != TO_MAX) begin
            to_cnt_r <= to_cnt_r + TO_ONE;
         end else begin
            to_cnt_r <= to_cnt_r;
         end
      end

      // Sticky timeout flag; a set in the same clock beats a clear
      always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
         if (wb_rst_i) begin
            irq_r <= 1'b0;
         end else if (to_set_s) begin
            irq_r <= 1'b1;
         end else if (irq_clr[k]) begin
            irq_r <= 1'b0;
         end else begin
            irq_r <= irq_r;
         end
      end

      assign timeout_irq[k] = irq_r;
`else
      logic unused_cfg_s;
      assign unused_cfg_s   = ^{irq_clr[k], TIMEOUT_CYC[0]};
      assign timeout_irq[k] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_i2c_pad_bridge.sv
// tb_i2c_pad_bridge: directed test of i2c_pad_bridge.
// Configuration: 2 channels, FILT_LEN=3, open-drain drive, TIMEOUT_CYC=16.
// The timeout section depends on I2C_PAD_TIMEOUT_EN.
module tb_i2c_pad_bridge;

   logic       wb_clk_i = 1'b0;
   logic       wb_rst_i;
   logic [1:0] m_scl_o;
   logic [1:0] m_scl_oen;
   logic [1:0] m_sda_o;
   logic [1:0] m_sda_oen;
   logic [1:0] m_scl_i;
   logic [1:0] m_sda_i;
   logic [3:0] pad_in;
   logic [3:0] pad_out;
   logic [3:0] pad_oeb;
   logic [1:0] start_det;
   logic [1:0] stop_det;
   logic [1:0] bus_busy;
   logic [1:0] timeout_irq;
   logic [1:0] irq_clr;

   int vectors     = 0;
   int miscompares = 0;
   int st_cnt [2];
   int sp_cnt [2];

   // 10 ns clock
   always #5 wb_clk_i = ~wb_clk_i;

   i2c_pad_bridge #(
      .N_CH        (2),
      .FILT_LEN    (3),
      .OPEN_DRAIN  (1),
      .TIMEOUT_CYC (16)
   ) dut (
      .wb_clk_i    (wb_clk_i),
      .wb_rst_i    (wb_rst_i),
      .m_scl_o     (m_scl_o),
      .m_scl_oen   (m_scl_oen),
      .m_sda_o     (m_sda_o),
      .m_sda_oen   (m_sda_oen),
      .m_scl_i     (m_scl_i),
      .m_sda_i     (m_sda_i),
      .pad_in      (pad_in),
      .pad_out     (pad_out),
      .pad_oeb     (pad_oeb),
      .start_det   (start_det),
      .stop_det    (stop_det),
      .bus_busy    (bus_busy),
      .timeout_irq (timeout_irq),
      .irq_clr     (irq_clr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n clock edges, sampling 1 ns after each edge and counting event pulses
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge wb_clk_i);
         #1;
         for (int k = 0; k < 2; k++) begin
            if (start_det[k] === 1'b1) st_cnt[k]++;
            if (stop_det[k]  === 1'b1) sp_cnt[k]++;
         end
      end
   endtask

   task automatic clr_cnt();
      for (int k = 0; k < 2; k++) begin
         st_cnt[k] = 0;
         sp_cnt[k] = 0;
      end
   endtask

   initial begin
      wb_rst_i  = 1'b1;
      pad_in    = 4'b1111;
      m_scl_o   = 2'b00;
      m_scl_oen = 2'b00;
      m_sda_o   = 2'b00;
      m_sda_oen = 2'b00;
      irq_clr   = 2'b00;
      clr_cnt();

      // Reset state
      run(3);
      chk("rst_scl_i", 32'(m_scl_i), 32'h3);
      chk("rst_sda_i", 32'(m_sda_i), 32'h3);
      chk("rst_busy",  32'(bus_busy), 32'h0);
      chk("rst_start", 32'(start_det), 32'h0);
      chk("rst_stop",  32'(stop_det), 32'h0);
      chk("rst_irq",   32'(timeout_irq), 32'h0);
      wb_rst_i = 1'b0;
      run(2);
      chk("idle_busy", 32'(bus_busy), 32'h0);

      // Open-drain pad drive
      m_sda_oen = 2'b01; m_sda_o = 2'b00; m_scl_oen = 2'b01; m_scl_o = 2'b01;
      #1;
      chk("od_oeb_sda_low", 32'(pad_oeb), 32'hD);
      chk("od_out_zero",    32'(pad_out), 32'h0);
      m_scl_o = 2'b00;
      #1;
      chk("od_oeb_scl_low", 32'(pad_oeb), 32'hC);
      m_scl_oen = 2'b00; m_sda_oen = 2'b10; m_sda_o = 2'b10;
      #1;
      chk("od_oeb_high_rel", 32'(pad_oeb), 32'hF);
      m_sda_oen = 2'b00; m_sda_o = 2'b00;

      // Glitch filter: a 2-clock glitch is rejected
      run(1);
      pad_in[0] = 1'b0;
      run(2);
      pad_in[0] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         run(1);
         chk("glitch_reject", 32'(m_scl_i), 32'h3);
      end
      // A 4-clock pulse falls 5 edges after the pad and rises 5 edges after it
      pad_in[0] = 1'b0;
      run(4);
      chk("pulse_e4_high", 32'(m_scl_i), 32'h3);
      pad_in[0] = 1'b1;
      run(1);
      chk("pulse_e5_low", 32'(m_scl_i), 32'h2);
      run(3);
      chk("pulse_e8_low", 32'(m_scl_i), 32'h2);
      run(1);
      chk("pulse_e9_high", 32'(m_scl_i), 32'h3);
      run(2);

      // Channel 1 START: one pulse and the bus goes busy
      clr_cnt();
      pad_in[3] = 1'b0;
      run(5);
      chk("ch1_start_e5_none", 32'(start_det), 32'h0);
      chk("ch1_busy_e5",       32'(bus_busy), 32'h0);
      run(1);
      chk("ch1_start_pulse", 32'(start_det), 32'h2);
      chk("ch1_busy_set",    32'(bus_busy), 32'h2);
      run(1);
      chk("ch1_start_1clk", 32'(start_det), 32'h0);
      chk("ch1_busy_hold",  32'(bus_busy), 32'h2);
      // Repeated START: SCL low, SDA high, SCL high, SDA low
      pad_in[2] = 1'b0; run(8);
      pad_in[3] = 1'b1; run(8);
      pad_in[2] = 1'b1; run(8);
      pad_in[3] = 1'b0; run(8);
      chk("rep_start_count", 32'(st_cnt[1]), 32'd2);
      chk("rep_start_nostop", 32'(sp_cnt[1]), 32'd0);
      chk("rep_start_busy", 32'(bus_busy), 32'h2);
      // STOP
      pad_in[3] = 1'b1; run(8);
      chk("ch1_stop_count", 32'(sp_cnt[1]), 32'd1);
      chk("ch1_stop_idle",  32'(bus_busy), 32'h0);
      chk("ch0_quiet", 32'(st_cnt[0] + sp_cnt[0]), 32'd0);

      // Ch1 set up with SDA low and SCL high, no events
      pad_in[2] = 1'b0; run(8);
      pad_in[3] = 1'b0; run(8);
      pad_in[2] = 1'b1; run(8);
      // START on ch0 and STOP on ch1 in the same clock
      clr_cnt();
      pad_in[1] = 1'b0;
      pad_in[3] = 1'b1;
      run(5);
      chk("dual_e5_start", 32'(start_det), 32'h0);
      chk("dual_e5_stop",  32'(stop_det), 32'h0);
      run(1);
      chk("dual_start", 32'(start_det), 32'h1);
      chk("dual_stop",  32'(stop_det), 32'h2);
      chk("dual_busy",  32'(bus_busy), 32'h1);
      run(3);
      // SDA and SCL changing in the same clock make no event
      clr_cnt();
      pad_in[0] = 1'b0; pad_in[1] = 1'b1; run(8);
      pad_in[0] = 1'b1; pad_in[1] = 1'b0; run(8);
      chk("sim_edge_start", 32'(st_cnt[0] + st_cnt[1]), 32'd0);
      chk("sim_edge_stop",  32'(sp_cnt[0] + sp_cnt[1]), 32'd0);
      chk("sim_edge_busy",  32'(bus_busy), 32'h1);

      // Asynchronous reset mid-byte, checked before the next clock edge
      pad_in[0] = 1'b0;
      run(3);
      wb_rst_i = 1'b1;
      #2;
      chk("arst_busy",  32'(bus_busy), 32'h0);
      chk("arst_scl_i", 32'(m_scl_i), 32'h3);
      chk("arst_sda_i", 32'(m_sda_i), 32'h3);
      pad_in = 4'b1111;
      run(2);
      wb_rst_i = 1'b0;
      run(3);

`ifdef I2C_PAD_TIMEOUT_EN
      // SCL low for 15 filtered clocks: no IRQ
      pad_in[2] = 1'b0; run(15);
      pad_in[2] = 1'b1; run(10);
      chk("to_15_none", 32'(timeout_irq), 32'h0);
      // Held low: IRQ on the 16th low clock
      pad_in[2] = 1'b0;
      run(20);
      chk("to_e20_none", 32'(timeout_irq), 32'h0);
      run(1);
      chk("to_16_set", 32'(timeout_irq), 32'h2);
      irq_clr = 2'b10;
      run(1);
      chk("to_set_wins", 32'(timeout_irq), 32'h2);
      irq_clr = 2'b00;
      pad_in[2] = 1'b1;
      run(8);
      chk("to_sticky", 32'(timeout_irq), 32'h2);
      irq_clr = 2'b10;
      run(1);
      irq_clr = 2'b00;
      chk("to_cleared", 32'(timeout_irq), 32'h0);
`else
      // Without the timeout feature the IRQ never asserts
      pad_in[2] = 1'b0;
      irq_clr   = 2'b11;
      run(40);
      irq_clr   = 2'b00;
      chk("to_disabled", 32'(timeout_irq), 32'h0);
      pad_in[2] = 1'b1;
      run(8);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
